pwm_encoder: RTL and testbench
==============================

// Module: pwm_encoder
// PURPOSE
//  Duty-to-waveform end of the PWM path: accepts 8-bit duty words (e.g. the 0..255..0
//  breathing ramp) via valid/ready and drives a registered PWM pin. Duty is double-buffered
//  and applied only at period boundaries (glitch-free). Sits between the ramp source and LED pin.
// PARAMETERS
//  PRESCALE  195  clk cycles per PWM slot (>=1); 256 slots per period (~1 kHz @ 50 MHz)
//  WIDTH     8    duty / slot-counter width; period = 2**WIDTH slots
// PORTS
//  clk           in   1      system clock; all logic on posedge clk
//  rst           in   1      async reset, active-high
//  enable        in   1      1 = run; 0 = stop at end of current period
//  duty_in       in   WIDTH  requested duty (high slots per period)
//  duty_valid    in   1      duty_in valid this cycle
//  duty_ready    out  1      pending buffer free; transfer on valid&ready
//  pwm_out       out  1      PWM waveform, registered
//  period_start  out  1      1-cycle pulse on first clk of each period
//  duty_active   out  WIDTH  duty currently being generated
// BEHAVIOUR
//  Reset (async, immediate, also mid-period): state=IDLE, presc=0, slot=0, duty_active=0,
//   pend_flag=0, pend_duty=0, pwm_out=0, period_start=0; duty_ready=1.
//  Prescaler: in RUN/STOP counts 0..PRESCALE-1, wraps; tick=1 when presc==PRESCALE-1.
//   Held at 0 in IDLE. PRESCALE=1 -> tick every cycle.
//  Slot counter: +1 on tick, wraps 2**WIDTH-1 -> 0 (modulo, no saturation); boundary = tick
//   with slot==2**WIDTH-1. Held at 0 in IDLE.
//  Handshake: duty_ready = ~pend_flag (comb). valid&ready -> pend_duty<=duty_in, pend_flag<=1.
//   valid while ready=0: not accepted, source holds. duty_in ignored without valid.
//  Apply: on boundary, or IDLE->RUN, if pend_flag: duty_active<=pend_duty, pend_flag<=0.
//   Transfer in the same cycle as a boundary lands in pend_duty, applied next boundary.
//  FSM:
//   IDLE: enable=1 -> RUN (apply pending duty, period_start=1 next cycle).
//   RUN : enable=0 -> STOP; keeps generating.
//   STOP: boundary -> IDLE; enable=1 before boundary -> RUN, no gap/restart.
//  pwm_out (registered, 1 cycle after slot value): (state!=IDLE) && (slot < duty_active).
//   duty 0 -> constantly low; duty 255 -> high 255 of 256 slots; never full-on.
//   IDLE -> pwm_out=0 next cycle.
//  period_start: 1-cycle pulse on cycle after boundary in RUN, or after IDLE->RUN; none
//   for the boundary ending STOP.
//  Unsigned compare, no width truncation; pending buffer depth 1.
// STRUCTURE
//  Shared header pwm_defs.vh: FSM encodings (IDLE/RUN/STOP), default PRESCALE and WIDTH;
//   shared with the ramp generator.
//  Sub-module pwm_prescaler (PRESCALE, clk, rst, run -> tick). Rest in pwm_encoder:
//   FSM, slot counter, duty buffer, output register.
// TESTING (bench PRESCALE=2, WIDTH=8)
//  1 Reset: rst=1 mid-period -> same cycle pwm_out=0, duty_active=0, duty_ready=1; stays
//    IDLE after release while enable=0.
//  2 Duty 64, enable=1 -> period_start once every 512 clk; pwm_out high exactly 128 clk/period.
//  3 Extremes: duty 0 -> pwm_out never high; duty 255 -> high 510 of 512 clk per period.
//  4 Mid-period update 64->200: duty_ready=0 until boundary; duty_active switches exactly at
//    next period_start; second valid while ready=0 not accepted.
//  5 Transfer on boundary cycle: new value not in the period just started, applied one
//    period later.
//  6 enable=0 mid-period -> period completes, then pwm_out=0 and IDLE, no period_start;
//    re-enable during STOP -> continuous periods, no missed period_start.

Source files
------------

// File: rtl/pwm_encoder_pkg.sv
// Shared PWM definitions: FSM encoding and default timing, also used by the ramp generator.
package pwm_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } pwm_state_e;

  // ~1 kHz period at 50 MHz with 256 slots
  localparam int unsigned PWM_PRESCALE_DEF = 195;
  localparam int unsigned PWM_WIDTH_DEF    = 8;

endpackage

// File: rtl/pwm_prescaler.sv
// Slot-rate prescaler: counts 0..PRESCALE-1 while running, tick on the last count.
module pwm_prescaler #(
  parameter int unsigned PRESCALE = 195
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] presc_q, presc_d;

  // With PRESCALE=1 the counter is stuck at 0 == LAST, so tick follows run.
  always_comb begin
    presc_d = presc_q;
    if (!run) begin
      presc_d = '0;
    end else if (presc_q == LAST) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  assign tick = run && (presc_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/pwm_encoder.sv
// PWM encoder: double-buffered duty accepted via valid/ready, applied at period
// boundaries, driving a registered glitch-free PWM pin.
module pwm_encoder
  import pwm_encoder_pkg::*;
#(
  parameter int unsigned PRESCALE = PWM_PRESCALE_DEF,
  parameter int unsigned WIDTH    = PWM_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic [WIDTH-1:0] duty_active
);

  pwm_state_e       state_q, state_d;
  logic [WIDTH-1:0] slot_q, slot_d;
  logic [WIDTH-1:0] duty_active_q, duty_active_d;
  logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
  logic             pend_flag_q, pend_flag_d;
  logic             pwm_out_q, pwm_out_d;
  logic             period_start_q, period_start_d;

  logic run, tick, boundary, start_run, xfer, apply;

  assign run       = (state_q != ST_IDLE);
  assign boundary  = tick && (slot_q == {WIDTH{1'b1}});
  assign start_run = (state_q == ST_IDLE) && enable;
  assign xfer      = duty_valid && !pend_flag_q;
  assign apply     = boundary || start_run;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_STOP;
      // Re-enable wins over the boundary so a late re-enable never drops a period.
      ST_STOP: begin
        if (enable) begin
          state_d = ST_RUN;
        end else if (boundary) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    slot_d = slot_q;
    if (!run) begin
      slot_d = '0;
    end else if (tick) begin
      slot_d = slot_q + 1'b1;
    end
  end

  // A transfer needs pend_flag_q=0 and an apply needs pend_flag_q=1, so they never
  // collide: a value accepted on a boundary waits for the following boundary.
  always_comb begin
    duty_active_d = duty_active_q;
    pend_duty_d   = pend_duty_q;
    pend_flag_d   = pend_flag_q;
    if (apply && pend_flag_q) begin
      duty_active_d = pend_duty_q;
      pend_flag_d   = 1'b0;
    end
    if (xfer) begin
      pend_duty_d = duty_in;
      pend_flag_d = 1'b1;
    end
  end

  assign pwm_out_d      = run && (slot_q < duty_active_q);
  assign period_start_d = start_run || (boundary && ((state_q == ST_RUN) || enable));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      slot_q         <= '0;
      duty_active_q  <= '0;
      pend_duty_q    <= '0;
      pend_flag_q    <= 1'b0;
      pwm_out_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      duty_active_q  <= duty_active_d;
      pend_duty_q    <= pend_duty_d;
      pend_flag_q    <= pend_flag_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign duty_ready   = !pend_flag_q;
  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;
  assign duty_active  = duty_active_q;

endmodule

// File: tb/tb_pwm_encoder.sv
// Bench for pwm_encoder: per-period scoreboard of duty, high time, length and continuation.
module tb_pwm_encoder;

  localparam int PRESCALE   = 2;
  localparam int WIDTH      = 8;
  localparam int PERIOD_CLK = PRESCALE * (1 << WIDTH);

  logic             clk;
  logic             rst;
  logic             enable;
  logic [WIDTH-1:0] duty_in;
  logic             duty_valid;
  logic             duty_ready;
  logic             pwm_out;
  logic             period_start;
  logic [WIDTH-1:0] duty_active;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int duty;
    int highs;
    int len;
    int cont;
  } per_t;

  typedef struct {
    logic [WIDTH-1:0] duty;
    int               exp_highs;
  } vec_t;

  per_t obs_q[$];
  per_t exp_q[$];
  int   obs_rd = 0;
  vec_t vec[6];

  pwm_encoder #(
    .PRESCALE (PRESCALE),
    .WIDTH    (WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_active  (duty_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Period monitor: a record opens on period_start and closes on the next
  // period_start or after one nominal period length, whichever comes first.
  int mon_open  = 0;
  int mon_highs = 0;
  int mon_len   = 0;
  int mon_duty  = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_open = 0;
    end else begin
      if (mon_open != 0 && (period_start || mon_len == PERIOD_CLK)) begin
        obs_q.push_back('{duty: mon_duty, highs: mon_highs, len: mon_len,
                          cont: int'(period_start)});
        mon_open = 0;
      end
      if (period_start) begin
        mon_open  = 1;
        mon_duty  = int'(duty_active);
        mon_highs = int'(pwm_out);
        mon_len   = 1;
      end else if (mon_open != 0) begin
        mon_highs = mon_highs + int'(pwm_out);
        mon_len   = mon_len + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drain();
    per_t o;
    per_t e;
    #1;
    while (obs_rd < obs_q.size()) begin
      o = obs_q[obs_rd];
      obs_rd++;
      if (exp_q.size() == 0) begin
        chk("unexpected_period", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("period_duty", o.duty, e.duty);
        chk("period_high_clks", o.highs, e.highs);
        chk("period_len", o.len, e.len);
        chk("period_continues", o.cont, e.cont);
      end
    end
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!period_start && n < 1200) begin
      @(negedge clk);
      n++;
    end
    if (!period_start) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    while (!duty_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!duty_ready) chk("send_ready_timeout", 0, 1);
    duty_in    = d;
    duty_valid = 1'b1;
    @(posedge clk);
    #1;
    duty_valid = 1'b0;
    duty_in    = WIDTH'($urandom);
  endtask

  task automatic quiet(input int n, input string name);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out || period_start) cnt++;
    end
    chk(name, cnt, 0);
  endtask

  initial begin
    int n;
    int bad;

    vec[0] = '{8'd0,   0};
    vec[1] = '{8'd255, 510};
    vec[2] = '{8'd1,   2};
    vec[3] = '{8'd128, 256};
    vec[4] = '{8'd200, 400};
    vec[5] = '{8'd64,  128};

    rst        = 1'b1;
    enable     = 1'b0;
    duty_valid = 1'b0;
    duty_in    = '0;
    #1;
    chk("reset_pwm_out", int'(pwm_out), 0);
    chk("reset_duty_active", int'(duty_active), 0);
    chk("reset_duty_ready", int'(duty_ready), 1);
    chk("reset_period_start", int'(period_start), 0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    quiet(20, "idle_after_reset");

    // Reset asserted mid-period with a pending duty.
    send(8'd64);
    enable = 1'b1;
    wait_start("first_start");
    drain();
    repeat (40) @(negedge clk);
    chk("pwm_high_mid_period", int'(pwm_out), 1);
    send(8'd77);
    chk("ready_low_pending", int'(duty_ready), 0);
    #2;
    rst    = 1'b1;
    enable = 1'b0;
    #1;
    chk("midrst_pwm_out", int'(pwm_out), 0);
    chk("midrst_duty_active", int'(duty_active), 0);
    chk("midrst_duty_ready", int'(duty_ready), 1);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    quiet(600, "idle_no_enable");
    chk("idle_duty_active", int'(duty_active), 0);
    drain();

    // Start-up with duty 64, then the table of duty vectors, one per period.
    send(8'd64);
    enable = 1'b1;
    exp_q.push_back('{duty: 64, highs: 128, len: PERIOD_CLK, cont: 1});
    wait_start("b_start");
    drain();
    chk("b_active", int'(duty_active), 64);
    for (int i = 0; i < 6; i++) begin
      send(vec[i].duty);
      exp_q.push_back('{duty: int'(vec[i].duty), highs: vec[i].exp_highs,
                        len: PERIOD_CLK, cont: 1});
      wait_start("vec_start");
      drain();
      chk("vec_active", int'(duty_active), int'(vec[i].duty));
    end

    // Mid-period update 64 -> 200; a second valid while not ready is dropped.
    repeat (200) @(negedge clk);
    send(8'd200);
    exp_q.push_back('{duty: 200, highs: 400, len: PERIOD_CLK, cont: 1});
    chk("c_ready_low", int'(duty_ready), 0);
    duty_in    = 8'd99;
    duty_valid = 1'b1;
    repeat (50) @(negedge clk);
    chk("c_held_active", int'(duty_active), 64);
    chk("c_held_ready", int'(duty_ready), 0);
    duty_valid = 1'b0;
    n   = 0;
    bad = 0;
    @(negedge clk);
    while (!period_start && n < 600) begin
      if (duty_ready || duty_active != 8'd64) bad++;
      @(negedge clk);
      n++;
    end
    chk("c_start_seen", int'(period_start), 1);
    chk("c_ready_low_until_boundary", bad, 0);
    chk("c_active_switch", int'(duty_active), 200);
    chk("c_ready_after_boundary", int'(duty_ready), 1);
    drain();

    // Transfer on the boundary cycle: held one more period before applying.
    exp_q.push_back('{duty: 200, highs: 400, len: PERIOD_CLK, cont: 1});
    exp_q.push_back('{duty: 250, highs: 500, len: PERIOD_CLK, cont: 0});
    repeat (PERIOD_CLK - 1) @(negedge clk);
    chk("d_ready_before_boundary", int'(duty_ready), 1);
    duty_in    = 8'd250;
    duty_valid = 1'b1;
    @(posedge clk);
    #1;
    duty_valid = 1'b0;
    @(negedge clk);
    chk("d_boundary_start", int'(period_start), 1);
    chk("d_active_unchanged", int'(duty_active), 200);
    chk("d_pending_held", int'(duty_ready), 0);
    drain();
    wait_start("d_next");
    drain();
    chk("d_active_applied", int'(duty_active), 250);

    // Disable mid-period: period completes, then idle with no period_start.
    repeat (100) @(negedge clk);
    enable = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 1200) begin
      @(negedge clk);
      drain();
      n++;
    end
    chk("e_stop_drained", exp_q.size(), 0);
    quiet(600, "e_stopped_quiet");
    drain();

    // Re-enable during STOP keeps periods back-to-back.
    enable = 1'b1;
    exp_q.push_back('{duty: 250, highs: 500, len: PERIOD_CLK, cont: 1});
    wait_start("e1_start");
    drain();
    repeat (100) @(negedge clk);
    enable = 1'b0;
    repeat (200) @(negedge clk);
    enable = 1'b1;
    exp_q.push_back('{duty: 250, highs: 500, len: PERIOD_CLK, cont: 0});
    wait_start("e2_start");
    drain();
    chk("e2_active", int'(duty_active), 250);
    enable = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 1200) begin
      @(negedge clk);
      drain();
      n++;
    end
    chk("e_final_drained", exp_q.size(), 0);
    quiet(600, "final_quiet");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
